// File: rtl/fft_bin_scaler_pkg.sv
// Shared widths and frame-tracker state for the FFT bin scaler.
package fft_bin_scaler_pkg;

  localparam int IN_W_DEF    = 18;
  localparam int EXP_W_DEF   = 6;
  localparam int DEN_W_DEF   = 32;
  localparam int GAIN_W_DEF  = 8;
  localparam int FRAC_SH_DEF = 15;
  localparam int OUT_W_DEF   = 20;
  localparam int IDX_W_DEF   = 10;

  typedef enum logic {
    IDLE,
    IN_FRAME
  } trk_state_e;

endpackage

// File: rtl/fft_bin_scaler_if.sv
// Sample-in / amplitude-out bundle of the FFT bin scaler, including the peak report.
interface fft_bin_scaler_if
  import fft_bin_scaler_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int EXP_W  = EXP_W_DEF,
  parameter int GAIN_W = GAIN_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int IDX_W  = IDX_W_DEF
) ();

  logic                    in_valid;
  logic                    in_sop;
  logic                    in_eop;
  logic        [IN_W-1:0]  in_mag;
  logic signed [EXP_W-1:0] in_exp;
  logic        [GAIN_W-1:0] gain;

  logic                    out_valid;
  logic        [OUT_W-1:0] out_data;
  logic                    out_sat;
  logic                    out_sop;
  logic                    out_eop;
  logic                    pk_valid;
  logic        [OUT_W-1:0] pk_data;
  logic        [IDX_W-1:0] pk_idx;

  modport master (
    output in_valid, in_sop, in_eop, in_mag, in_exp, gain,
    input  out_valid, out_data, out_sat, out_sop, out_eop, pk_valid, pk_data, pk_idx
  );

  modport slave (
    input  in_valid, in_sop, in_eop, in_mag, in_exp, gain,
    output out_valid, out_data, out_sat, out_sop, out_eop, pk_valid, pk_data, pk_idx
  );

endinterface

// File: rtl/fft_bin_scaler_peak_tracker.sv
// Frame tracker: follows sop/eop on the scaled stream and reports each frame's first maximum.
module fft_peak_tracker
  import fft_bin_scaler_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic             s_sop,
  input  logic             s_eop,
  input  logic [OUT_W-1:0] s_data,
  output logic             pk_valid,
  output logic [OUT_W-1:0] pk_data,
  output logic [IDX_W-1:0] pk_idx
);

  trk_state_e       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] peak_q, peak_d;
  logic [IDX_W-1:0] pidx_q, pidx_d;
  logic             pk_valid_q, pk_valid_d;
  logic [OUT_W-1:0] pk_data_q, pk_data_d;
  logic [IDX_W-1:0] pk_idx_q, pk_idx_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    peak_d     = peak_q;
    pidx_d     = pidx_q;
    pk_valid_d = 1'b0;
    pk_data_d  = pk_data_q;
    pk_idx_d   = pk_idx_q;
    if (s_valid) begin
      // A new sop always restarts the frame, silently dropping any open one.
      if (s_sop) begin
        state_d = IN_FRAME;
        peak_d  = s_data;
        pidx_d  = '0;
        cnt_d   = IDX_W'(1);
      end else if (state_q == IN_FRAME) begin
        if (s_data > peak_q) begin
          peak_d = s_data;
          pidx_d = cnt_q;
        end
        cnt_d = cnt_q + IDX_W'(1);
      end
      if (s_eop && (s_sop || state_q == IN_FRAME)) begin
        pk_valid_d = 1'b1;
        pk_data_d  = peak_d;
        pk_idx_d   = pidx_d;
        state_d    = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      peak_q     <= '0;
      pidx_q     <= '0;
      pk_valid_q <= 1'b0;
      pk_data_q  <= '0;
      pk_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      peak_q     <= peak_d;
      pidx_q     <= pidx_d;
      pk_valid_q <= pk_valid_d;
      pk_data_q  <= pk_data_d;
      pk_idx_q   <= pk_idx_d;
    end
  end

  assign pk_valid = pk_valid_q;
  assign pk_data  = pk_data_q;
  assign pk_idx   = pk_idx_q;

endmodule

// File: rtl/fft_bin_scaler.sv
// Block-floating-point bin to saturated fixed-point amplitude, 3-stage pipeline.
// Define FFT_BIN_SCALER_PEAK_EN to include the per-frame peak tracker.
module fft_bin_scaler
  import fft_bin_scaler_pkg::*;
#(
  parameter int IN_W    = IN_W_DEF,
  parameter int EXP_W   = EXP_W_DEF,
  parameter int DEN_W   = DEN_W_DEF,
  parameter int GAIN_W  = GAIN_W_DEF,
  parameter int FRAC_SH = FRAC_SH_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int IDX_W   = IDX_W_DEF
) (
  input logic             clk,
  input logic             rst_n,
  fft_bin_scaler_if.slave bus
);

  localparam int PROD_W = DEN_W + GAIN_W;
  // Wide enough to hold the largest left shift before checking overflow.
  localparam int SH_W   = DEN_W + (1 << (EXP_W - 1));

  function automatic logic [DEN_W:0] denorm(input logic [IN_W-1:0] mag,
                                            input logic signed [EXP_W-1:0] e);
    logic [EXP_W-1:0] amt;
    logic [SH_W-1:0]  wide;
    logic             sat;
    logic [DEN_W-1:0] den;
    amt = $unsigned(e);
    if (e[EXP_W-1]) amt = ~amt + EXP_W'(1);
    if (e[EXP_W-1]) begin
      wide = SH_W'(mag) << amt;
      sat  = |wide[SH_W-1:DEN_W];
      den  = sat ? '1 : wide[DEN_W-1:0];
    end else begin
      sat = 1'b0;
      den = DEN_W'(mag >> amt);
    end
    return {sat, den};
  endfunction

  function automatic logic [OUT_W:0] clamp(input logic [PROD_W-1:0] prod, input logic sat);
    logic [PROD_W-1:0] sh;
    sh = prod >> FRAC_SH;
    if (sat || (|sh[PROD_W-1:OUT_W])) return {1'b1, {OUT_W{1'b1}}};
    return {1'b0, sh[OUT_W-1:0]};
  endfunction

  logic              vld_p0_q, vld_p0_d, sop_p0_q, sop_p0_d, eop_p0_q, eop_p0_d;
  logic [DEN_W-1:0]  den_p0_q, den_p0_d;
  logic              sat_p0_q, sat_p0_d;
  logic [GAIN_W-1:0] gain_p0_q, gain_p0_d;

  logic              vld_p1_q, vld_p1_d, sop_p1_q, sop_p1_d, eop_p1_q, eop_p1_d;
  logic [PROD_W-1:0] prod_p1_q, prod_p1_d;
  logic              sat_p1_q, sat_p1_d;

  logic              vld_p2_q, vld_p2_d, sop_p2_q, sop_p2_d, eop_p2_q, eop_p2_d;
  logic [OUT_W-1:0]  data_p2_q, data_p2_d;
  logic              osat_p2_q, osat_p2_d;

  always_comb begin
    // p0: denormalise
    vld_p0_d              = bus.in_valid;
    sop_p0_d              = bus.in_valid & bus.in_sop;
    eop_p0_d              = bus.in_valid & bus.in_eop;
    {sat_p0_d, den_p0_d}  = denorm(bus.in_mag, bus.in_exp);
    gain_p0_d             = bus.gain;
    // p1: gain multiply
    vld_p1_d              = vld_p0_q;
    sop_p1_d              = sop_p0_q;
    eop_p1_d              = eop_p0_q;
    prod_p1_d             = PROD_W'(den_p0_q) * PROD_W'(gain_p0_q);
    sat_p1_d              = sat_p0_q;
    // p2: fixed shift and clamp; output data holds across bubbles
    vld_p2_d              = vld_p1_q;
    sop_p2_d              = sop_p1_q;
    eop_p2_d              = eop_p1_q;
    data_p2_d             = data_p2_q;
    osat_p2_d             = osat_p2_q;
    if (vld_p1_q) {osat_p2_d, data_p2_d} = clamp(prod_p1_q, sat_p1_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0_q  <= 1'b0;
      sop_p0_q  <= 1'b0;
      eop_p0_q  <= 1'b0;
      vld_p1_q  <= 1'b0;
      sop_p1_q  <= 1'b0;
      eop_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      sop_p2_q  <= 1'b0;
      eop_p2_q  <= 1'b0;
      data_p2_q <= '0;
      osat_p2_q <= 1'b0;
    end else begin
      vld_p0_q  <= vld_p0_d;
      sop_p0_q  <= sop_p0_d;
      eop_p0_q  <= eop_p0_d;
      vld_p1_q  <= vld_p1_d;
      sop_p1_q  <= sop_p1_d;
      eop_p1_q  <= eop_p1_d;
      vld_p2_q  <= vld_p2_d;
      sop_p2_q  <= sop_p2_d;
      eop_p2_q  <= eop_p2_d;
      data_p2_q <= data_p2_d;
      osat_p2_q <= osat_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    den_p0_q  <= den_p0_d;
    sat_p0_q  <= sat_p0_d;
    gain_p0_q <= gain_p0_d;
    prod_p1_q <= prod_p1_d;
    sat_p1_q  <= sat_p1_d;
  end

  assign bus.out_valid = vld_p2_q;
  assign bus.out_data  = data_p2_q;
  assign bus.out_sat   = osat_p2_q;
  assign bus.out_sop   = sop_p2_q;
  assign bus.out_eop   = eop_p2_q;

`ifdef FFT_BIN_SCALER_PEAK_EN
  fft_peak_tracker #(
    .OUT_W (OUT_W),
    .IDX_W (IDX_W)
  ) u_peak (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (vld_p2_q),
    .s_sop    (sop_p2_q),
    .s_eop    (eop_p2_q),
    .s_data   (data_p2_q),
    .pk_valid (bus.pk_valid),
    .pk_data  (bus.pk_data),
    .pk_idx   (bus.pk_idx)
  );
`else
  assign bus.pk_valid = 1'b0;
  assign bus.pk_data  = '0;
  assign bus.pk_idx   = IDX_W'(0);
`endif

endmodule

// File: tb/tb_fft_bin_scaler.sv
// Scoreboard bench for fft_bin_scaler: arithmetic reference model plus frame-peak model.
`timescale 1ns/1ps
module tb_fft_bin_scaler;
  import fft_bin_scaler_pkg::*;

  localparam int OUT_W = OUT_W_DEF;
  localparam int IDX_W = IDX_W_DEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_bin_scaler_if bus ();

  fft_bin_scaler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             sat;
    logic             sop;
    logic             eop;
    int               stamp;
  } out_exp_t;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [IDX_W-1:0] idx;
    int               stamp;
  } pk_exp_t;

  out_exp_t         oq[$];
  pk_exp_t          pq[$];
  logic [OUT_W-1:0] fr[$];
  bit               in_frame = 0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int n_in = 0;
  int n_out = 0;
  int n_drop = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: value = floor(mag * 2^-exp * gain / 2^15), clamped to 20 bits.
  function automatic void model(input int mag, input int e, input int g,
                                output logic [OUT_W-1:0] d, output logic s);
    longint unsigned den, prod, r;
    bit ov;
    ov = 0;
    if (e < 0) begin
      den = longint'(mag) << (-e);
      if (den >= (64'd1 << 32)) begin
        ov  = 1;
        den = (64'd1 << 32) - 1;
      end
    end else begin
      den = longint'(mag) >> e;
    end
    prod = den * longint'(g);
    r    = prod >> 15;
    if (ov || r > 64'd1048575) begin
      d = '1;
      s = 1'b1;
    end else begin
      d = r[OUT_W-1:0];
      s = 1'b0;
    end
  endfunction

  task automatic issue(input logic [17:0] mag, input logic signed [5:0] e,
                       input logic [7:0] g, input logic sop, input logic eop);
    logic [OUT_W-1:0] d;
    logic             s;
    int               bi;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_sop   = sop;
    bus.in_eop   = eop;
    bus.in_mag   = mag;
    bus.in_exp   = e;
    bus.gain     = g;
    n_in++;
    model(int'(mag), int'(e), int'(g), d, s);
    oq.push_back('{d, s, sop, eop, cyc});
    if (sop) begin
      fr.delete();
      fr.push_back(d);
      in_frame = 1;
    end else if (in_frame) begin
      fr.push_back(d);
    end
    if (eop && in_frame) begin
      bi = 0;
      for (int i = 1; i < fr.size(); i++) if (fr[i] > fr[bi]) bi = i;
      pq.push_back('{fr[bi], IDX_W'(bi % (1 << IDX_W)), cyc + 4});
      in_frame = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_sop   = 1'($urandom_range(0, 1));
      bus.in_eop   = 1'($urandom_range(0, 1));
      bus.in_mag   = 18'($urandom);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 0);
    check({tag, "_out_data"},  64'(bus.out_data), 0);
    check({tag, "_out_sat"},   64'(bus.out_sat), 0);
    check({tag, "_out_sop"},   64'(bus.out_sop), 0);
    check({tag, "_out_eop"},   64'(bus.out_eop), 0);
    check({tag, "_pk_valid"},  64'(bus.pk_valid), 0);
    check({tag, "_pk_data"},   64'(bus.pk_data), 0);
    check({tag, "_pk_idx"},    64'(bus.pk_idx), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        n_out++;
        if (oq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected actual data %0d required no output", bus.out_data);
        end else begin
          out_exp_t e;
          e = oq.pop_front();
          check("out_data", 64'(bus.out_data), 64'(e.data));
          check("out_sat", 64'(bus.out_sat), 64'(e.sat));
          check("out_sop", 64'(bus.out_sop), 64'(e.sop));
          check("out_eop", 64'(bus.out_eop), 64'(e.eop));
          check("out_latency", 64'(cyc), 64'(e.stamp + 3));
        end
      end
`ifdef FFT_BIN_SCALER_PEAK_EN
      if (bus.pk_valid) begin
        if (pq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pk_spurious actual data %0d idx %0d required no report", bus.pk_data, bus.pk_idx);
        end else begin
          pk_exp_t p;
          p = pq.pop_front();
          check("pk_data", 64'(bus.pk_data), 64'(p.data));
          check("pk_idx", 64'(bus.pk_idx), 64'(p.idx));
          check("pk_timing", 64'(cyc), 64'(p.stamp));
        end
      end
`else
      if (bus.out_valid)
        check("pk_tied", {bus.pk_valid, bus.pk_data, bus.pk_idx}, 0);
`endif
    end
  end

  initial begin
    int ei;
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
    bus.in_mag   = '0;
    bus.in_exp   = '0;
    bus.gain     = '0;
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    issue(18'd131071, 6'sd0, 8'd50, 0, 0);
    issue(18'd131071, -6'sd2, 8'd50, 0, 0);
    issue(18'd131071, 6'sd3, 8'd50, 0, 0);
    issue(18'd131071, -6'sd12, 8'd255, 0, 0);
    issue(18'd131071, -6'sd20, 8'd1, 0, 0);
    issue(18'd1, -6'sd32, 8'd255, 0, 0);
    idle(3);

    issue(18'd5, -6'sd15, 8'd1, 1, 0);
    issue(18'd9, -6'sd15, 8'd1, 0, 0);
    issue(18'd9, -6'sd15, 8'd1, 0, 0);
    issue(18'd3, -6'sd15, 8'd1, 0, 1);
    idle(2);
    issue(18'd7, -6'sd15, 8'd1, 0, 1);
    idle(2);

    issue(18'd50, -6'sd15, 8'd1, 1, 0);
    issue(18'd2, -6'sd15, 8'd1, 0, 0);
    issue(18'd7, -6'sd15, 8'd1, 1, 0);
    issue(18'd4, -6'sd15, 8'd1, 0, 0);
    issue(18'd6, -6'sd15, 8'd1, 0, 1);
    issue(18'd12, -6'sd15, 8'd1, 1, 1);
    idle(3);

    issue(18'd20, -6'sd15, 8'd1, 1, 0);
    issue(18'd30, -6'sd15, 8'd1, 0, 0);
    issue(18'd40, -6'sd15, 8'd1, 0, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    n_drop += oq.size();
    oq.delete();
    pq.delete();
    fr.delete();
    in_frame = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    issue(18'd3, -6'sd15, 8'd1, 0, 1);
    idle(3);

    for (int i = 0; i < 1030; i++)
      issue((i == 1027) ? 18'd9 : 18'd1, -6'sd15, 8'd1, i == 0, i == 1029);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1 + $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) ei = int'($urandom_range(0, 16)) - 8;
      else ei = int'($urandom_range(0, 63)) - 32;
      issue(18'($urandom), 6'(ei), 8'($urandom),
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end
    idle(10);

    check("out_queue_empty", 64'(oq.size()), 0);
    check("out_count", 64'(n_out), 64'(n_in - n_drop));
`ifdef FFT_BIN_SCALER_PEAK_EN
    check("pk_queue_empty", 64'(pq.size()), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_bin_scaler.md
# fft_bin_scaler

Parametrised multi-stage scaler for FFT output bins. It converts each block-floating-point magnitude (mantissa plus signed block exponent) into a saturated fixed-point amplitude: denormalise, multiply by a runtime gain, then apply a fixed right shift. The block sits between the FFT core's magnitude output and the measurement/display logic. It also optionally reports the per-frame peak bin.

## Interface
Parameters:
- IN_W, 18, unsigned mantissa width
- EXP_W, 6, signed block-exponent width (two's complement)
- DEN_W, 32, denormalised intermediate width
- GAIN_W, 8, unsigned gain width
- FRAC_SH, 15, fixed right shift after multiply
- OUT_W, 20, output width
- IDX_W, 10, bin-index width (frame length ≤ 2^IDX_W)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input sample qualifier
- in_sop  in  1  first bin of frame (valid only with in_valid)
- in_eop  in  1  last bin of frame (valid only with in_valid)
- in_mag  in  IN_W  unsigned mantissa
- in_exp  in  EXP_W  signed exponent, sampled per sample
- gain  in  GAIN_W  unsigned gain, sampled with in_valid
- out_valid  out  1  output qualifier
- out_data  out  OUT_W  scaled amplitude
- out_sat  out  1  out_data was clamped
- out_sop / out_eop  out  1  delayed frame markers
- pk_valid  out  1  one-cycle peak-report strobe
- pk_data  out  OUT_W  frame maximum
- pk_idx  out  IDX_W  bin index of maximum

## Operation
- Stage 1, denormalise: if in_exp < 0, shift in_mag left by |in_exp|; otherwise shift right by in_exp. The shift amount and the data come from the same sample. If a left shift loses any set bit beyond DEN_W, force all-ones and set the stage sat flag.
- Stage 2, multiply: full-width product DEN_W+GAIN_W; sat flag propagates.
- Stage 3, shift and clamp: shift the product right by FRAC_SH (truncate). If the result exceeds 2^OUT_W−1 or the sat flag is set, output 2^OUT_W−1 with out_sat=1. Otherwise out_sat=0.
- There is no backpressure. Every in_valid sample produces exactly one out_valid sample. Bubbles are preserved.
- Frame tracker (peak feature):
  - States IDLE and IN_FRAME, driven by stage-3 markers.
  - out_sop: go to IN_FRAME, reset the bin counter to 0, load the peak with the current sample. This applies even if already IN_FRAME, which aborts the old frame with no report.
  - Each valid sample in frame: compare against the current peak. A strictly greater value replaces it, so ties keep the earliest index. The counter increments and wraps modulo 2^IDX_W.
  - out_eop in IN_FRAME: next cycle pk_valid=1 with the final pk_data/pk_idx, then return to IDLE. out_eop while IDLE is ignored.
  - sop and eop on the same sample form a one-bin frame and report that bin at index 0.
  - Valid samples while IDLE pass through scaling only.

## Timing
- Latency is 3 cycles from in_valid to out_valid. Throughput is one sample per clock.
- pk_valid asserts 1 cycle after the out_valid carrying out_eop.
- pk_data/pk_idx hold their values until the next report.
- Reset values: all outputs 0; tracker in IDLE; pipeline valids cleared. Asserting reset mid-frame discards the frame with no pk_valid.
- gain is sampled per sample, so changing it mid-frame affects only subsequent samples.

## Configuration
- FFT_BIN_SCALER_PEAK_EN defined: the frame tracker is present as described.
- Undefined: the tracker is removed, pk_valid, pk_data and pk_idx are tied to 0, and scaling is unchanged.

## Structure
- The shared package holds the default widths, FRAC_SH, and the tracker state enum (IDLE, IN_FRAME).
- Sub-module fft_peak_tracker holds the frame FSM, bin counter and compare logic. It is instantiated only under the macro.

## Test plan
- mag=131071, exp=0, gain=50 -> out_data=199, out_sat=0, 3 cycles later.
- mag=131071, exp=−2 (6'b111110), gain=50 -> 799; same mag with exp=+3 -> 24.
- mag=131071, exp=−12, gain=255 -> 1048575, out_sat=1. With exp=−20 the DEN_W overflow also saturates.
- Frame with outputs 5, 9, 9, 3 (sop on the first, eop on the last) -> pk_valid one cycle after the last output, pk_data=9, pk_idx=1.
- Two mid-frame cases, each giving no pk_valid for the aborted frame:
  - second sop mid-frame -> the report covers only the new frame;
  - rst_n pulse mid-frame -> all outputs 0 immediately.
- Back-to-back in_valid with gaps, plus an eop while IDLE -> output count equals input count, and no spurious pk_valid.
